banco_registradores: RTL and testbench
======================================

// Module: banco_registradores
// PURPOSE
//   32-entry register file with a pending-write scoreboard, sitting directly upstream of the ALU.
//   SaidaA/SaidaB drive the ALU EntradaA/EntradaB; ALU results return through the write port.
//   Reads are combinational with write-through bypass, so the ALU sees the newest value in the same cycle.
//   Per-register busy bits flag operands whose producer has not yet written back (RAW hazard), for stall control.
// PARAMETERS
//   DATA_WIDTH  32  width of each register and of all data ports
//   ADDR_WIDTH  5   register address width; NUM_REGS = 2**ADDR_WIDTH
// PORTS
//   Clock            in   1           rising-edge clock
//   Reset            in   1           asynchronous, active-high reset
//   EnderecoA        in   ADDR_WIDTH  read address, port A
//   EnderecoB        in   ADDR_WIDTH  read address, port B
//   SaidaA           out  DATA_WIDTH  read data A (to ALU EntradaA)
//   SaidaB           out  DATA_WIDTH  read data B (to ALU EntradaB)
//   OcupadoA         out  1           register at EnderecoA has a pending, unwritten result
//   OcupadoB         out  1           register at EnderecoB has a pending, unwritten result
//   EscritaEn        in   1           write enable (ALU result write-back)
//   EnderecoEscrita  in   ADDR_WIDTH  write address
//   DadoEscrita      in   DATA_WIDTH  write data (ALU Saida)
//   ReservaEn        in   1           mark destination register as pending (instruction issue)
//   EnderecoReserva  in   ADDR_WIDTH  register to reserve
//   Conflito         out  1           ReservaEn targets a register that is already busy (WAW)
// BEHAVIOUR
//   Reset (async, any time, including mid-operation): all registers = 0 and all busy bits = 0, immediately.
//     After reset, SaidaA/B = 0 and OcupadoA/B = Conflito = 0.
//   Register 0: always reads 0 and is never busy; writes and reservations to address 0 are ignored.
//   Read: combinational, 0-cycle latency. SaidaX = reg[EnderecoX].
//   Bypass: if EscritaEn and EnderecoEscrita == EnderecoX != 0, then SaidaX = DadoEscrita in the same cycle.
//   Write: reg[EnderecoEscrita] <= DadoEscrita on the rising edge when EscritaEn = 1 and the address is nonzero.
//   Scoreboard, per register r != 0, updated on the rising edge:
//     - ReservaEn and EnderecoReserva == r                      -> busy[r] <= 1
//     - else EscritaEn and EnderecoEscrita == r                 -> busy[r] <= 0
//     - Reserve and write to the same r in the same cycle: data is written AND busy stays 1 (a new producer wins).
//     - Write to a non-busy register: allowed; busy stays 0.
//     - Reserve of an already-busy register: busy stays 1 (no counting); Conflito = 1 that cycle.
//   OcupadoX = busy[EnderecoX] & ~(EscritaEn & EnderecoEscrita == EnderecoX), forced to 0 when EnderecoX == 0.
//     The bypassed write resolves the hazard in the same cycle.
//   Conflito = ReservaEn & (EnderecoReserva != 0) & busy[EnderecoReserva] (combinational).
//   Reads on A and B may use the same address; both ports return identical data and busy flags.
//   No arithmetic; data is stored verbatim. Full-width values, e.g. 32'hFFFFFFFF, are held without truncation.
// TESTING
//   1. Assert Reset mid-run after writes -> all SaidaA/B = 0, OcupadoA/B = 0 without waiting for a clock edge.
//   2. Write r5 = 2001 and r6 = 4001, then read A = 5, B = 6 -> SaidaA = 2001, SaidaB = 4001.
//   3. Write r0 = 32'hFFFFFFFF and reserve r0; read A = 0 -> SaidaA = 0, OcupadoA = 0, Conflito = 0.
//   4. Reserve r7; next cycle read A = 7 -> OcupadoA = 1.
//      Then EscritaEn with r7 = 32'hFFFFFFFF -> SaidaA = FFFFFFFF and OcupadoA = 0 in that cycle; busy[7] = 0 after the edge.
//   5. With r9 busy, reserve r9 again -> Conflito = 1 and busy[9] stays 1.
//      Reserve r9 and write r9 = 1 in the same cycle -> reg[9] = 1 and OcupadoA (A = 9) = 1 after the edge.
//   6. Read A = B = 12 while writing r12 = 3 -> SaidaA = SaidaB = 3 in the same cycle.

Source files
------------

// File: rtl/banco_registradores_if.sv
// Register-file access bus: two read ports, ALU write-back port, issue-time reservation port.
// Latency: pure signal bundle, no storage.
// Backpressure: none; stalls are derived by the consumer from the Ocupado/Conflito flags.
interface banco_registradores_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic [ADDR_WIDTH-1:0] EnderecoA;
    logic [ADDR_WIDTH-1:0] EnderecoB;
    logic [DATA_WIDTH-1:0] SaidaA;
    logic [DATA_WIDTH-1:0] SaidaB;
    logic                  OcupadoA;
    logic                  OcupadoB;
    logic                  EscritaEn;
    logic [ADDR_WIDTH-1:0] EnderecoEscrita;
    logic [DATA_WIDTH-1:0] DadoEscrita;
    logic                  ReservaEn;
    logic [ADDR_WIDTH-1:0] EnderecoReserva;
    logic                  Conflito;

    // Issue/write-back side: drives addresses, write data and reservations
    modport master (
        output EnderecoA, EnderecoB,
        output EscritaEn, EnderecoEscrita, DadoEscrita,
        output ReservaEn, EnderecoReserva,
        input  SaidaA, SaidaB, OcupadoA, OcupadoB, Conflito
    );

    // Register file side
    modport slave (
        input  EnderecoA, EnderecoB,
        input  EscritaEn, EnderecoEscrita, DadoEscrita,
        input  ReservaEn, EnderecoReserva,
        output SaidaA, SaidaB, OcupadoA, OcupadoB, Conflito
    );
endinterface

// File: rtl/banco_registradores.sv
// 32-entry register file with write-through bypass and per-register pending-write (busy) scoreboard.
// Latency: reads and hazard flags are combinational (0 cycles); writes/reservations take effect on the rising edge.
// Backpressure: none internally; OcupadoA/B and Conflito are exported so issue logic can stall.
module banco_registradores #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input logic                  Clock,
    input logic                  Reset,
    banco_registradores_if.slave bus
);
    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [NUM_REGS-1:0]   busy;

    logic wr_ok;
    logic rsv_ok;

    // Address 0 is hardwired: writes and reservations to it are dropped
    assign wr_ok  = bus.EscritaEn && (bus.EnderecoEscrita != '0);
    assign rsv_ok = bus.ReservaEn && (bus.EnderecoReserva != '0);

    // Register storage: verbatim store of write-back data
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_ok) begin
            regs[bus.EnderecoEscrita] <= bus.DadoEscrita;
        end
    end

    // Scoreboard: write-back clears, reservation sets; the later statement wins so a
    // reservation in the same cycle as a write-back to the same register keeps it busy
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            busy <= '0;
        end else begin
            if (wr_ok) begin
                busy[bus.EnderecoEscrita] <= 1'b0;
            end
            if (rsv_ok) begin
                busy[bus.EnderecoReserva] <= 1'b1;
            end
        end
    end

    // Read ports with bypass: an in-flight write both supplies the data and resolves the hazard
    always_comb begin
        bus.SaidaA   = '0;
        bus.SaidaB   = '0;
        bus.OcupadoA = 1'b0;
        bus.OcupadoB = 1'b0;
        if (bus.EnderecoA != '0) begin
            if (bus.EscritaEn && (bus.EnderecoEscrita == bus.EnderecoA)) begin
                bus.SaidaA = bus.DadoEscrita;
            end else begin
                bus.SaidaA   = regs[bus.EnderecoA];
                bus.OcupadoA = busy[bus.EnderecoA];
            end
        end
        if (bus.EnderecoB != '0) begin
            if (bus.EscritaEn && (bus.EnderecoEscrita == bus.EnderecoB)) begin
                bus.SaidaB = bus.DadoEscrita;
            end else begin
                bus.SaidaB   = regs[bus.EnderecoB];
                bus.OcupadoB = busy[bus.EnderecoB];
            end
        end
    end

    // WAW detection: reserving a register whose previous producer has not written back
    assign bus.Conflito = rsv_ok && busy[bus.EnderecoReserva];

endmodule

// File: tb/tb_banco_registradores.sv
// Directed self-checking bench for banco_registradores.
// Inputs are driven 1 time unit after the rising edge, outputs sampled 1 unit later.
// No backpressure; the bench drives the bus directly.
module tb_banco_registradores;
    logic Clock;
    logic Reset;
    int   checks;
    int   errors;

    banco_registradores_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

    banco_registradores #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic idle();
        bus.EscritaEn = 1'b0;
        bus.ReservaEn = 1'b0;
        bus.EnderecoEscrita = '0;
        bus.EnderecoReserva = '0;
        bus.DadoEscrita = '0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        Reset = 1'b1;
        bus.EnderecoA = 5'd5;
        bus.EnderecoB = 5'd6;
        idle();
        #2;
        check("reset_saidaA", bus.SaidaA, 32'd0);
        check("reset_saidaB", bus.SaidaB, 32'd0);
        check("reset_ocupA", {31'd0, bus.OcupadoA}, 32'd0);
        check("reset_conflito", {31'd0, bus.Conflito}, 32'd0);

        // Write r5 and r6, then read them back
        tick();
        Reset = 1'b0;
        tick();
        bus.EscritaEn = 1'b1; bus.EnderecoEscrita = 5'd5; bus.DadoEscrita = 32'd2001;
        tick();
        bus.EnderecoEscrita = 5'd6; bus.DadoEscrita = 32'd4001;
        tick();
        idle();
        #1;
        check("read_r5", bus.SaidaA, 32'd2001);
        check("read_r6", bus.SaidaB, 32'd4001);

        // Reserve r5, then async reset mid-cycle clears data and busy
        bus.ReservaEn = 1'b1; bus.EnderecoReserva = 5'd5;
        tick();
        idle();
        #1;
        check("busy_r5", {31'd0, bus.OcupadoA}, 32'd1);
        Reset = 1'b1;
        #1;
        check("async_rst_saidaA", bus.SaidaA, 32'd0);
        check("async_rst_saidaB", bus.SaidaB, 32'd0);
        check("async_rst_ocupA", {31'd0, bus.OcupadoA}, 32'd0);
        tick();
        Reset = 1'b0;

        // Register 0: write and reserve ignored
        bus.EnderecoA = 5'd0; bus.EnderecoB = 5'd0;
        bus.EscritaEn = 1'b1; bus.EnderecoEscrita = 5'd0; bus.DadoEscrita = 32'hFFFFFFFF;
        bus.ReservaEn = 1'b1; bus.EnderecoReserva = 5'd0;
        #1;
        check("r0_bypass", bus.SaidaA, 32'd0);
        check("r0_conflito", {31'd0, bus.Conflito}, 32'd0);
        tick();
        idle();
        #1;
        check("r0_after_saida", bus.SaidaA, 32'd0);
        check("r0_after_ocup", {31'd0, bus.OcupadoA}, 32'd0);

        // Reserve r7, then resolve it via bypassed write-back
        bus.ReservaEn = 1'b1; bus.EnderecoReserva = 5'd7;
        tick();
        idle();
        bus.EnderecoA = 5'd7;
        #1;
        check("r7_busy", {31'd0, bus.OcupadoA}, 32'd1);
        check("r7_data_before", bus.SaidaA, 32'd0);
        bus.EscritaEn = 1'b1; bus.EnderecoEscrita = 5'd7; bus.DadoEscrita = 32'hFFFFFFFF;
        #1;
        check("r7_bypass_data", bus.SaidaA, 32'hFFFFFFFF);
        check("r7_bypass_ocup", {31'd0, bus.OcupadoA}, 32'd0);
        tick();
        idle();
        #1;
        check("r7_after_ocup", {31'd0, bus.OcupadoA}, 32'd0);
        check("r7_after_data", bus.SaidaA, 32'hFFFFFFFF);

        // r9: WAW conflict, then reserve+write in the same cycle
        bus.ReservaEn = 1'b1; bus.EnderecoReserva = 5'd9;
        #1;
        check("r9_first_conflito", {31'd0, bus.Conflito}, 32'd0);
        tick();
        #1;
        check("r9_conflito", {31'd0, bus.Conflito}, 32'd1);
        tick();
        idle();
        bus.EnderecoA = 5'd9; bus.EnderecoB = 5'd9;
        #1;
        check("r9_still_busyA", {31'd0, bus.OcupadoA}, 32'd1);
        check("r9_still_busyB", {31'd0, bus.OcupadoB}, 32'd1);
        bus.ReservaEn = 1'b1; bus.EnderecoReserva = 5'd9;
        bus.EscritaEn = 1'b1; bus.EnderecoEscrita = 5'd9; bus.DadoEscrita = 32'd1;
        tick();
        idle();
        #1;
        check("r9_rsv_wr_data", bus.SaidaA, 32'd1);
        check("r9_rsv_wr_busy", {31'd0, bus.OcupadoA}, 32'd1);
        bus.EscritaEn = 1'b1; bus.EnderecoEscrita = 5'd9; bus.DadoEscrita = 32'd5;
        tick();
        idle();
        #1;
        check("r9_cleared", {31'd0, bus.OcupadoB}, 32'd0);
        check("r9_final_data", bus.SaidaB, 32'd5);

        // Same address on both ports while writing a non-busy register
        bus.EnderecoA = 5'd12; bus.EnderecoB = 5'd12;
        bus.EscritaEn = 1'b1; bus.EnderecoEscrita = 5'd12; bus.DadoEscrita = 32'd3;
        #1;
        check("r12_bypassA", bus.SaidaA, 32'd3);
        check("r12_bypassB", bus.SaidaB, 32'd3);
        tick();
        idle();
        #1;
        check("r12_storedA", bus.SaidaA, 32'd3);
        check("r12_ocupB", {31'd0, bus.OcupadoB}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
